// File: rtl/array_34_pkg.sv
// Shared widths, enums and the SRAM command payload for the array_34 access controller.
package array_34_pkg;

   localparam int unsigned ADDR_W      = 8;
   localparam int unsigned MASK_SEG    = 8;
   localparam int unsigned MASK_GRAN   = 21;
   localparam int unsigned DATA_W      = MASK_SEG * MASK_GRAN;
   localparam int unsigned ARRAY_DEPTH = 256;

   typedef enum logic {INIT, RUN} state_t;
   typedef enum logic {READ, WRITE} req_t;

   typedef struct packed {
      logic                en;
      logic                wmode;
      logic [ADDR_W-1:0]   addr;
      logic [MASK_SEG-1:0] wmask;
      logic [DATA_W-1:0]   wdata;
   } sram_cmd_t;

endpackage

// File: rtl/array_34_resp_fifo.sv
// Shift-style response FIFO; the head entry is a register driving the output directly.
module array_34_resp_fifo
   import array_34_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         push,
   input  logic [DATA_W-1:0]            push_data,
   input  logic                         pop,
   output logic                         valid,
   output logic [DATA_W-1:0]            data,
   output logic [$clog2(DEPTH + 1)-1:0] count
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned IDX_W = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [CNT_W-1:0]  count_nxt;
   logic [CNT_W-1:0]  wr_idx;
   logic              do_pop;

   assign do_pop    = pop && valid;
   assign wr_idx    = count - CNT_W'(do_pop);
   assign count_nxt = count + CNT_W'(push) - CNT_W'(do_pop);
   assign data      = mem[0];

   // Pop shifts everything toward the head; push lands behind the surviving entries.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count <= '0;
         valid <= 1'b0;
         for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      end else begin
         if (do_pop) begin
            for (int i = 0; i < int'(DEPTH) - 1; i++) mem[i] <= mem[i + 1];
         end
         if (push && (wr_idx < CNT_W'(DEPTH))) mem[wr_idx[IDX_W-1:0]] <= push_data;
         count <= count_nxt;
         valid <= (count_nxt != '0);
      end
   end

endmodule

// File: rtl/array_34_ctrl.sv
// Single-port controller for array_34_ext: write/read arbitration, read response FIFO,
// and optional post-reset zero sweep.
module array_34_ctrl
   import array_34_pkg::*;
#(
   parameter bit          INIT_ENABLE = 1'b1,
   parameter int unsigned RESP_DEPTH  = 2
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                wr_valid,
   output logic                wr_ready,
   input  logic [ADDR_W-1:0]   wr_addr,
   input  logic [MASK_SEG-1:0] wr_mask,
   input  logic [DATA_W-1:0]   wr_data,
   input  logic                rd_valid,
   output logic                rd_ready,
   input  logic [ADDR_W-1:0]   rd_addr,
   output logic                resp_valid,
   input  logic                resp_ready,
   output logic [DATA_W-1:0]   resp_data,
   output logic                init_done,
   output logic [ADDR_W-1:0]   sram_addr,
   output logic                sram_en,
   output logic                sram_wmode,
   output logic [MASK_SEG-1:0] sram_wmask,
   output logic [DATA_W-1:0]   sram_wdata,
   input  logic [DATA_W-1:0]   sram_rdata
);

   localparam int unsigned CNT_W = $clog2(RESP_DEPTH + 1);
   localparam int unsigned OCC_W = CNT_W + 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ARRAY_DEPTH - 1);

   state_t            state;
   req_t              last_grant;
   logic [ADDR_W-1:0] sweep_cnt;
   logic              live;
   logic              inflight;
   logic [CNT_W-1:0]  fifo_count;
   logic [OCC_W-1:0]  occupancy;
   logic              pop;
   logic              rd_elig;
   logic              wr_elig;
   logic              grant_wr;
   logic              grant_rd;
   sram_cmd_t         cmd;

   // Credit: entries held plus the read still in the SRAM, less the one leaving now.
   assign pop       = resp_valid && resp_ready;
   assign occupancy = OCC_W'(fifo_count) + OCC_W'(inflight) - OCC_W'(pop);

   assign rd_elig  = live && (state == RUN) && rd_valid && (occupancy < OCC_W'(RESP_DEPTH));
   assign wr_elig  = live && (state == RUN) && wr_valid;
   assign grant_wr = wr_elig && (!rd_elig || (last_grant == READ));
   assign grant_rd = rd_elig && !grant_wr;

   assign wr_ready = grant_wr;
   assign rd_ready = grant_rd;

   // `live` holds every output low from reset until the first clock edge.
   always_comb begin
      cmd = '0;
      if (live && (state == INIT)) begin
         cmd.en    = 1'b1;
         cmd.wmode = 1'b1;
         cmd.addr  = sweep_cnt;
         cmd.wmask = '1;
      end else if (grant_wr) begin
         cmd.en    = |wr_mask;
         cmd.wmode = 1'b1;
         cmd.addr  = wr_addr;
         cmd.wmask = wr_mask;
         cmd.wdata = wr_data;
      end else if (grant_rd) begin
         cmd.en    = 1'b1;
         cmd.addr  = rd_addr;
      end
   end

   assign sram_en    = cmd.en;
   assign sram_wmode = cmd.wmode;
   assign sram_addr  = cmd.addr;
   assign sram_wmask = cmd.wmask;
   assign sram_wdata = cmd.wdata;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         if (INIT_ENABLE) state <= INIT;
         else             state <= RUN;
         sweep_cnt  <= '0;
         live       <= 1'b0;
         init_done  <= 1'b0;
         inflight   <= 1'b0;
         last_grant <= READ;
      end else begin
         live     <= 1'b1;
         inflight <= grant_rd;
         // Round-robin pointer only moves when both channels competed.
         if (rd_elig && wr_elig) begin
            if (grant_wr) last_grant <= WRITE;
            else          last_grant <= READ;
         end
         case (state)
            INIT: begin
               if (live) begin
                  sweep_cnt <= sweep_cnt + ADDR_W'(1);
                  if (sweep_cnt == LAST_ADDR) begin
                     state     <= RUN;
                     init_done <= 1'b1;
                  end
               end
            end
            RUN:     init_done <= 1'b1;
            default: state     <= INIT;
         endcase
      end
   end

   array_34_resp_fifo #(
      .DEPTH(RESP_DEPTH)
   ) u_resp_fifo (
      .clock    (clock),
      .reset    (reset),
      .push     (inflight),
      .push_data(sram_rdata),
      .pop      (pop),
      .valid    (resp_valid),
      .data     (resp_data),
      .count    (fifo_count)
   );

endmodule

// File: tb/tb_array_34_ctrl.sv
// Scoreboard bench for array_34_ctrl with a behavioural array_34_ext model.
module tb_array_34_ctrl;
   import array_34_pkg::*;

   localparam int unsigned RESP_DEPTH = 2;
   localparam logic [DATA_W-1:0] SEG0_ONES = 168'h1FFFFF;

   logic                clock = 1'b0;
   logic                reset = 1'b1;
   logic                wr_valid = 1'b0;
   logic                wr_ready;
   logic [ADDR_W-1:0]   wr_addr = '0;
   logic [MASK_SEG-1:0] wr_mask = '0;
   logic [DATA_W-1:0]   wr_data = '0;
   logic                rd_valid = 1'b0;
   logic                rd_ready;
   logic [ADDR_W-1:0]   rd_addr = '0;
   logic                resp_valid;
   logic                resp_ready = 1'b1;
   logic [DATA_W-1:0]   resp_data;
   logic                init_done;
   logic [ADDR_W-1:0]   sram_addr;
   logic                sram_en;
   logic                sram_wmode;
   logic [MASK_SEG-1:0] sram_wmask;
   logic [DATA_W-1:0]   sram_wdata;
   logic [DATA_W-1:0]   sram_rdata = '0;

   logic [DATA_W-1:0] smem [ARRAY_DEPTH] = '{default: {21{8'hA5}}};
   logic [DATA_W-1:0] exp_q [$];
   int n_checks = 0;
   int n_fail   = 0;
   int overflow = 0;

   always #5 clock = ~clock;

   array_34_ctrl #(.INIT_ENABLE(1'b1), .RESP_DEPTH(RESP_DEPTH)) dut (
      .clock(clock), .reset(reset),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
      .wr_mask(wr_mask), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
      .init_done(init_done),
      .sram_addr(sram_addr), .sram_en(sram_en), .sram_wmode(sram_wmode),
      .sram_wmask(sram_wmask), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
   );

   // array_34_ext model: masked write, 1-cycle registered read.
   always @(posedge clock) begin
      if (sram_en) begin
         if (sram_wmode) begin
            for (int s = 0; s < int'(MASK_SEG); s++)
               if (sram_wmask[s]) smem[sram_addr][s*MASK_GRAN +: MASK_GRAN] <= sram_wdata[s*MASK_GRAN +: MASK_GRAN];
         end else begin
            sram_rdata <= smem[sram_addr];
         end
      end
   end

   function automatic logic [DATA_W-1:0] pat(input int k);
      pat = {21{8'(k + 16)}};
   endfunction

   task automatic check(input string name, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic monitor();
      logic [DATA_W-1:0] e;
      forever begin
         @(negedge clock);
         if (dut.u_resp_fifo.push && (int'(dut.u_resp_fifo.count) >= int'(RESP_DEPTH)) && !dut.u_resp_fifo.pop)
            overflow++;
         if (resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_resp got=%h exp=none", resp_data);
            end else begin
               e = exp_q.pop_front();
               check("resp_data", resp_data, e);
            end
         end
      end
   endtask

   // Called at a negedge with reset high; releases reset and checks the full sweep.
   task automatic check_init_sweep(input string tag);
      int writes;
      int bad;
      writes   = 0;
      bad      = 0;
      wr_valid = 1'b1; wr_addr = 8'h33; wr_mask = 8'hFF; wr_data = '1;
      rd_valid = 1'b1; rd_addr = 8'h33;
      reset    = 1'b0;
      for (int k = 0; k <= 256; k++) begin
         @(negedge clock);
         if (sram_en && sram_wmode) writes++;
         if (k < 256) begin
            if (!(sram_en && sram_wmode && (sram_addr == 8'(k)) && (sram_wmask == 8'hFF) &&
                  (sram_wdata == '0) && !wr_ready && !rd_ready)) bad++;
         end
         if (k == 254) begin wr_valid = 1'b0; rd_valid = 1'b0; end
         if (k == 255) check({tag, "_init_done_c255"}, DATA_W'(init_done), DATA_W'(0));
         if (k == 256) check({tag, "_init_done_c256"}, DATA_W'(init_done), DATA_W'(1));
      end
      check({tag, "_sweep_writes"}, DATA_W'(writes), DATA_W'(256));
      check({tag, "_sweep_bad_cycles"}, DATA_W'(bad), DATA_W'(0));
   endtask

   // Tasks below start and end at posedge+1.
   task automatic do_write(input logic [ADDR_W-1:0] a, input logic [MASK_SEG-1:0] m, input logic [DATA_W-1:0] d);
      int n;
      n = 0;
      wr_valid = 1'b1; wr_addr = a; wr_mask = m; wr_data = d;
      @(negedge clock);
      while (!wr_ready && n < 50) begin @(negedge clock); n++; end
      if (!wr_ready) begin n_checks++; n_fail++; $display("FAIL wr_timeout addr=%h got=not_ready exp=ready", a); end
      @(posedge clock); #1;
      wr_valid = 1'b0;
   endtask

   task automatic do_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] e);
      int n;
      n = 0;
      rd_valid = 1'b1; rd_addr = a;
      @(negedge clock);
      while (!rd_ready && n < 50) begin @(negedge clock); n++; end
      if (rd_ready) exp_q.push_back(e);
      else begin n_checks++; n_fail++; $display("FAIL rd_timeout addr=%h got=not_ready exp=ready", a); end
      @(posedge clock); #1;
      rd_valid = 1'b0;
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin @(negedge clock); n++; end
      check({tag, "_drained"}, DATA_W'(exp_q.size()), DATA_W'(0));
      repeat (4) @(negedge clock);
      @(posedge clock); #1;
   endtask

   initial begin
      int accepted;
      int w;
      int n;
      logic [DATA_W-1:0] d1;
      logic [DATA_W-1:0] d2;
      d1 = {21{8'h3C}};
      d2 = {21{8'hC3}};
      fork monitor(); join_none

      // Reset state.
      repeat (2) @(negedge clock);
      check("rst_ctrl_outs", DATA_W'({wr_ready, rd_ready, resp_valid, init_done, sram_en, sram_wmode, sram_addr, sram_wmask}), '0);
      check("rst_sram_wdata", sram_wdata, '0);
      check("rst_resp_data", resp_data, '0);

      check_init_sweep("boot");
      @(posedge clock); #1;
      do_read(8'h80, '0);
      drain("zero_read");

      // Single-segment masked write, then zero-mask write that must not touch the array.
      do_write(8'h12, 8'h01, '1);
      do_read(8'h12, SEG0_ONES);
      wr_valid = 1'b1; wr_addr = 8'h12; wr_mask = 8'h00; wr_data = '0;
      @(negedge clock);
      check("mask0_ready_en", DATA_W'({wr_ready, sram_en}), DATA_W'(2'b10));
      @(posedge clock); #1;
      wr_valid = 1'b0;
      do_read(8'h12, SEG0_ONES);
      drain("mask");

      // Write->read and read->write hazards on consecutive cycles.
      do_write(8'h55, 8'hFF, d1);
      do_read(8'h55, d1);
      do_read(8'h55, d1);
      do_write(8'h55, 8'hFF, d2);
      do_read(8'h55, d2);
      drain("order");

      // Back-to-back reads with free downstream.
      for (int k = 0; k < 4; k++) do_write(8'(k), 8'hFF, pat(k));
      drain("preload");
      for (int k = 0; k < 8; k++) begin
         if (k < 4) begin rd_valid = 1'b1; rd_addr = 8'(k); end
         else rd_valid = 1'b0;
         @(negedge clock);
         if (k < 4) begin
            check("b2b_rd_ready", DATA_W'(rd_ready), DATA_W'(1));
            if (rd_ready) exp_q.push_back(pat(k));
         end
         check("b2b_resp_valid", DATA_W'(resp_valid), DATA_W'((k >= 2) && (k <= 5)));
         @(posedge clock); #1;
      end
      drain("b2b");

      // Backpressure: credits stop reads after two, then resume without loss.
      resp_ready = 1'b0;
      rd_valid = 1'b1; rd_addr = 8'h00; accepted = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clock);
         if (rd_ready) begin exp_q.push_back(pat(accepted)); accepted++; end
         @(posedge clock); #1;
         rd_addr = 8'(accepted);
      end
      @(negedge clock);
      check("bp_accepted", DATA_W'(accepted), DATA_W'(2));
      check("bp_rd_ready_low", DATA_W'(rd_ready), DATA_W'(0));
      check("bp_resp_held", DATA_W'(resp_valid), DATA_W'(1));
      @(posedge clock); #1;
      resp_ready = 1'b1;
      n = 0;
      while (accepted < 4 && n < 50) begin
         @(negedge clock);
         if (rd_ready) begin exp_q.push_back(pat(accepted)); accepted++; end
         @(posedge clock); #1;
         rd_addr = 8'(accepted);
         n++;
      end
      rd_valid = 1'b0;
      check("bp_resume_accepted", DATA_W'(accepted), DATA_W'(4));
      drain("bp");

      // Contention: grants alternate W,R,... starting with WRITE.
      w = 0;
      wr_valid = 1'b1; wr_mask = 8'hFF; wr_addr = 8'h40; wr_data = pat(8'h40);
      rd_valid = 1'b1; rd_addr = 8'h12;
      for (int k = 0; k < 6; k++) begin
         @(negedge clock);
         check("arb_grant", DATA_W'({wr_ready, rd_ready, sram_en}), DATA_W'((k % 2 == 0) ? 3'b101 : 3'b011));
         if (rd_ready) exp_q.push_back(SEG0_ONES);
         if (wr_ready) w++;
         @(posedge clock); #1;
         wr_addr = 8'(8'h40 + w);
         wr_data = pat(8'h40 + w);
      end
      wr_valid = 1'b0; rd_valid = 1'b0;
      do_read(8'h41, pat(8'h41));
      drain("arb");

      // Reset one cycle after a read grant: the read must vanish and the sweep restart.
      rd_valid = 1'b1; rd_addr = 8'h12;
      @(negedge clock);
      check("midrst_rd_granted", DATA_W'(rd_ready), DATA_W'(1));
      @(posedge clock); #1;
      rd_valid = 1'b0;
      reset = 1'b1;
      #1;
      check("midrst_ctrl_outs", DATA_W'({wr_ready, rd_ready, resp_valid, init_done, sram_en, sram_wmode, sram_addr, sram_wmask}), '0);
      check("midrst_resp_data", resp_data, '0);
      repeat (2) @(negedge clock);
      check_init_sweep("rerun");
      @(posedge clock); #1;
      do_read(8'h12, '0);
      drain("post_rst");

      check("fifo_push_while_full", DATA_W'(overflow), DATA_W'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/array_34_ctrl.md
Name: array_34_ctrl

Overview:
- Single-port access controller that sits directly upstream of the array_34_ext SRAM macro (256 x 168, 8 mask segments of 21 bits, 1-cycle read).
- Arbitrates independent write and read request channels onto the one RW port, with valid/ready on each channel.
- Captures read data into a response FIFO, so downstream backpressure never loses the transient SRAM output.
- Optionally zero-fills the whole array after reset.

Parameters:
INIT_ENABLE, 1, 1 = sweep-write zeros to all 256 entries after reset; 0 = enter RUN directly
RESP_DEPTH, 2, response FIFO entries (>=2); 2 sustains one read per cycle

Ports:
clock  input  1  clock
reset  input  1  asynchronous, active-high reset
wr_valid  input  1  write request valid
wr_ready  output  1  write request accepted this cycle
wr_addr  input  8  write address
wr_mask  input  8  per-21-bit-segment write enable
wr_data  input  168  write data
rd_valid  input  1  read request valid
rd_ready  output  1  read request accepted this cycle
rd_addr  input  8  read address
resp_valid  output  1  read response valid
resp_ready  input  1  downstream accepts response
resp_data  output  168  read response data
init_done  output  1  high once the array is usable
sram_addr  output  8  to RW0_addr
sram_en  output  1  to RW0_en
sram_wmode  output  1  to RW0_wmode
sram_wmask  output  8  to RW0_wmask
sram_wdata  output  168  to RW0_wdata
sram_rdata  input  168  from RW0_rdata

Behaviour:
- Reset values (asserted asynchronously):
  - all outputs 0
  - state = INIT if INIT_ENABLE, else RUN
  - sweep counter 0
  - FIFO empty, in-flight flag 0, last-grant = READ
- INIT state:
  - Each cycle drives sram_en=1, wmode=1, wmask=8'hFF, wdata=0, addr=cnt; cnt++.
  - After addr 255 is written, go to RUN.
  - init_done rises on the 257th rising edge after reset deassertion (cycle 256); it stays high until the next reset.
  - wr_ready and rd_ready are 0 throughout INIT.
- RUN state: one grant per cycle.
  - Read eligible when rd_valid && (fifo_count + inflight - pop) < RESP_DEPTH, where pop = resp_valid && resp_ready.
  - Write eligible when wr_valid.
  - If both are eligible, grant the one not granted last (round-robin). last-grant updates only on contended cycles.
  - Ready may depend combinationally on the valids and on resp_ready. There is no ready-to-valid path.
- SRAM drive:
  - Granted write: sram_en=1, wmode=1, addr/mask/data passed through unchanged.
  - Write with wr_mask == 0: accepted (wr_ready=1) but sram_en=0.
  - Granted read: sram_en=1, wmode=0, addr=rd_addr.
  - No grant: sram_en=0. Other sram outputs are don't-care but must not toggle X.
- Read pipeline:
  - Read accepted in cycle T sets inflight; sram_rdata is sampled into the FIFO at the T+1 edge.
  - resp_valid asserts in cycle T+2 at the earliest. There is no bypass path.
  - sram_rdata is sampled only in the cycle after a read grant; it is garbage otherwise.
- Ordering:
  - Responses are returned in request order.
  - Write in T, read of the same address in T+1: the read returns the new data.
  - Read in T, write of the same address in T+1: the read returns the old data.
- FIFO:
  - Push and pop in the same cycle is allowed when full.
  - The credit rule guarantees no push ever arrives while the FIFO is full; a bench assertion checks this.
- Reset mid-operation: FIFO is flushed, any in-flight read is discarded, and the INIT sweep restarts from address 0.

Decomposition:
- Package array_34_pkg:
  - ADDR_W=8, DATA_W=168, MASK_SEG=8, MASK_GRAN=21, ARRAY_DEPTH=256
  - state enum {INIT, RUN}
  - request-type enum {READ, WRITE}
- Sub-module array_34_resp_fifo:
  - Parameterised depth, DATA_W wide, registered output.
  - push/pop/count ports, asynchronous active-high reset.

Test Plan:
- Reset release, INIT_ENABLE=1 -> exactly 256 writes (addr 0..255, wmask FF, data 0); init_done high at cycle 256. A subsequent read of 0x80 returns 0.
- Write 0x12 mask 8'h01 data all ones, then read 0x12 -> resp_data = 168'h1FFFFF (bits 20:0 set, rest 0).
- resp_ready=1, reads 0x00..0x03 on consecutive cycles -> rd_ready high every cycle; resp_valid high cycles T+2..T+5 with data in address order.
- resp_ready=0, rd_valid held -> exactly 2 reads accepted, then rd_ready low. Raising resp_ready resumes with no lost or duplicated response.
- wr_valid and rd_valid both held high -> grants alternate W,R,W,R (first grant WRITE after reset); SRAM port busy every cycle.
- Reset asserted one cycle after a read grant -> outputs 0 immediately; no response ever appears for that read; INIT restarts at addr 0.
